au_seq_arbiter: RTL and testbench

Controller that shares one combinational 8-bit arithmetic unit (AU) between two requesters, A and B. It arbitrates between them and sequences each accepted op through the AU. An op is either one 8-bit pass or two chained passes (low byte, then high byte) that form a 16-bit result. The block sits between the requester logic and the AU instance and owns every AU input.

---
 rtl/au_seq_arbiter_pkg.sv | 36 +++
 rtl/au_seq_arbiter_if.sv | 30 +++
 rtl/au_seq_arbiter_arb.sv | 36 +++
 rtl/au_seq_arbiter.sv | 126 ++++++++++++
 tb/tb_au_seq_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/au_seq_arbiter_pkg.sv
// Shared types for the two-requester AU sequencer: FSM states, AU op codes,
// and the byte-chaining rule that maps a low-pass result onto the high-pass op.
package au_seq_arbiter_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_RESP} state_t;

  typedef logic [2:0] au_op_t;

  localparam au_op_t OP_PASSX = 3'b000;
  localparam au_op_t OP_INC   = 3'b001;
  localparam au_op_t OP_ADD   = 3'b010;
  localparam au_op_t OP_ADDC  = 3'b011;
  localparam au_op_t OP_SUB   = 3'b100;
  localparam au_op_t OP_SUBB  = 3'b101;
  localparam au_op_t OP_DEC   = 3'b110;
  localparam au_op_t OP_PASSY = 3'b111;

  typedef struct packed {
    au_op_t      op;
    logic        wide;
    logic [15:0] x;
    logic [15:0] y;
  } req_t;

  // Subtract mode inverts cin inside the AU, so the borrow is fed back as ~carry.
  // Decrement only propagates into the high byte when the low byte wrapped.
  function automatic au_op_t hi_op(input au_op_t op, input logic c_lo);
    case (op[2:1])
      2'b00:   return {2'b00, c_lo};
      2'b01:   return {2'b01, c_lo};
      2'b10:   return {2'b10, ~c_lo};
      default: return op[0] ? OP_PASSY : (c_lo ? OP_PASSX : OP_DEC);
    endcase
  endfunction

endpackage

// File: rtl/au_seq_arbiter_if.sv
// Request, response and AU-drive signals between the sequencer (slave) and
// its surroundings (master: requesters, result consumer, AU instance).
interface au_seq_arbiter_if;
  logic        a_valid, a_ready, a_wide;
  logic [2:0]  a_op;
  logic [15:0] a_x, a_y;
  logic        b_valid, b_ready, b_wide;
  logic [2:0]  b_op;
  logic [15:0] b_x, b_y;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [15:0] rsp_f;
  logic        au_sel1, au_sel0, au_cin, au_cout;
  logic [7:0]  au_x, au_y, au_f;

  modport slave (
    input  a_valid, a_op, a_wide, a_x, a_y,
    input  b_valid, b_op, b_wide, b_x, b_y,
    input  rsp_ready, au_f, au_cout,
    output a_ready, b_ready, rsp_valid, rsp_id, rsp_f, rsp_cout,
    output au_sel1, au_sel0, au_cin, au_x, au_y
  );

  modport master (
    output a_valid, a_op, a_wide, a_x, a_y,
    output b_valid, b_op, b_wide, b_x, b_y,
    output rsp_ready, au_f, au_cout,
    input  a_ready, b_ready, rsp_valid, rsp_id, rsp_f, rsp_cout,
    input  au_sel1, au_sel0, au_cin, au_x, au_y
  );
endinterface

// File: rtl/au_seq_arbiter_arb.sv
// Two-input arbiter: round-robin on acceptance, or fixed A-first priority.
module au_rr_arb2 #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic ptr_b;  // 1: B was not served last and wins a tie

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        if (FIXED_PRIO != 0 || !ptr_b) gnt_a = 1'b1;
        else                           gnt_b = 1'b1;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr_b <= 1'b0;
    else if (gnt_a) ptr_b <= 1'b1;
    else if (gnt_b) ptr_b <= 1'b0;
  end

endmodule

// File: rtl/au_seq_arbiter.sv
// Shares one 8-bit combinational AU between requesters A and B; wide ops run
// as a low pass then a carry-chained high pass before the result is offered.
module au_seq_arbiter
  import au_seq_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  au_seq_arbiter_if.slave bus
);

  state_t      state, state_nxt;
  req_t        cur, cur_nxt, req_a, req_b, req_sel;
  logic        id, id_nxt;
  logic [7:0]  lo, lo_nxt;
  au_op_t      au_op, au_op_nxt;
  logic [7:0]  au_x, au_x_nxt, au_y, au_y_nxt;
  logic [15:0] rsp_f, rsp_f_nxt;
  logic        rsp_cout, rsp_cout_nxt;
  logic        gnt_a, gnt_b, idle;

  assign idle    = (state == ST_IDLE);
  assign req_a   = '{op: bus.a_op, wide: bus.a_wide, x: bus.a_x, y: bus.a_y};
  assign req_b   = '{op: bus.b_op, wide: bus.b_wide, x: bus.b_x, y: bus.b_y};
  assign req_sel = gnt_b ? req_b : req_a;

  au_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (idle),
    .req_a (bus.a_valid),
    .req_b (bus.b_valid),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  always_comb begin
    state_nxt    = state;
    cur_nxt      = cur;
    id_nxt       = id;
    lo_nxt       = lo;
    au_op_nxt    = au_op;
    au_x_nxt     = au_x;
    au_y_nxt     = au_y;
    rsp_f_nxt    = rsp_f;
    rsp_cout_nxt = rsp_cout;
    case (state)
      ST_IDLE: begin
        if (gnt_a || gnt_b) begin
          cur_nxt   = req_sel;
          id_nxt    = gnt_b;
          au_op_nxt = req_sel.op;
          au_x_nxt  = req_sel.x[7:0];
          au_y_nxt  = req_sel.y[7:0];
          state_nxt = ST_LO;
        end
      end
      ST_LO: begin
        lo_nxt = bus.au_f;
        if (cur.wide) begin
          au_op_nxt = hi_op(cur.op, bus.au_cout);
          au_x_nxt  = cur.x[15:8];
          au_y_nxt  = cur.y[15:8];
          state_nxt = ST_HI;
        end else begin
          rsp_f_nxt    = {8'h00, bus.au_f};
          rsp_cout_nxt = (cur.op == OP_PASSY) ? 1'b0 : bus.au_cout;
          state_nxt    = ST_RESP;
        end
      end
      ST_HI: begin
        rsp_f_nxt = {bus.au_f, lo};
        // The high pass of a decrement may be a plain pass, so its carry
        // is meaningless; the true no-borrow flag is simply x != 0.
        case (cur.op)
          OP_DEC:   rsp_cout_nxt = |cur.x;
          OP_PASSY: rsp_cout_nxt = 1'b0;
          default:  rsp_cout_nxt = bus.au_cout;
        endcase
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur      <= '0;
      id       <= 1'b0;
      lo       <= 8'h00;
      au_op    <= OP_PASSX;
      au_x     <= 8'h00;
      au_y     <= 8'h00;
      rsp_f    <= 16'h0000;
      rsp_cout <= 1'b0;
    end else begin
      state    <= state_nxt;
      cur      <= cur_nxt;
      id       <= id_nxt;
      lo       <= lo_nxt;
      au_op    <= au_op_nxt;
      au_x     <= au_x_nxt;
      au_y     <= au_y_nxt;
      rsp_f    <= rsp_f_nxt;
      rsp_cout <= rsp_cout_nxt;
    end
  end

  assign bus.a_ready   = idle & gnt_a;
  assign bus.b_ready   = idle & gnt_b;
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_id    = id;
  assign bus.rsp_f     = rsp_f;
  assign bus.rsp_cout  = rsp_cout;
  assign bus.au_sel1   = au_op[2];
  assign bus.au_sel0   = au_op[1];
  assign bus.au_cin    = au_op[0];
  assign bus.au_x      = au_x;
  assign bus.au_y      = au_y;

endmodule

// File: tb/tb_au_seq_arbiter.sv
// Bench for au_seq_arbiter: behavioural AU, vector table + scoreboard, and
// directed sequences for arbitration, back-pressure and mid-op reset.
module tb_au_seq_arbiter;

  typedef struct {
    logic        port;
    logic [2:0]  op;
    logic        wide;
    logic [15:0] x, y, f;
    logic        cout;
  } vec_t;

  typedef struct {
    logic        id;
    logic [15:0] f;
    logic        cout;
  } exp_t;

  logic clk, rst_n;
  int   checks = 0, errors = 0;
  int   nf = 0;
  exp_t sb[$];
  logic last_id;
  vec_t tbl[14];
  exp_t exp_a, exp_b;

  au_seq_arbiter_if bus();
  au_seq_arbiter_if busf();

  au_seq_arbiter #(.FIXED_PRIO(0)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  au_seq_arbiter #(.FIXED_PRIO(1)) dutf (.clk(clk), .rst_n(rst_n), .bus(busf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // AU behaviour: {cout, f}; subtract is x + ~y + ~cin, so cout is no-borrow
  function automatic logic [8:0] au_model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      3'b000:  return {1'b0, x};
      3'b001:  return {1'b0, x} + 9'd1;
      3'b010:  return {1'b0, x} + {1'b0, y};
      3'b011:  return {1'b0, x} + {1'b0, y} + 9'd1;
      3'b100:  return {1'b0, x} + {1'b0, ~y} + 9'd1;
      3'b101:  return {1'b0, x} + {1'b0, ~y};
      3'b110:  return {1'b0, x} + 9'h0FF;
      default: return {1'b0, y};
    endcase
  endfunction

  // Whole-width reference result {cout, f} for 8- or 16-bit ops
  function automatic logic [16:0] ref_op(input logic [2:0] op, input logic wide, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] m, xx, yy, s;
    logic        c;
    m  = wide ? 17'h0FFFF : 17'h000FF;
    xx = {1'b0, x} & m;
    yy = {1'b0, y} & m;
    case (op)
      3'b000:  s = xx;
      3'b001:  s = xx + 17'd1;
      3'b010:  s = xx + yy;
      3'b011:  s = xx + yy + 17'd1;
      3'b100:  s = xx + (yy ^ m) + 17'd1;
      3'b101:  s = xx + (yy ^ m);
      3'b110:  s = xx + m;
      default: s = yy;
    endcase
    c = wide ? s[16] : s[8];
    return {c, s[15:0] & m[15:0]};
  endfunction

  logic [8:0] au_r, au_rf;
  assign au_r         = au_model({bus.au_sel1, bus.au_sel0, bus.au_cin}, bus.au_x, bus.au_y);
  assign bus.au_f     = au_r[7:0];
  assign bus.au_cout  = au_r[8];
  assign au_rf        = au_model({busf.au_sel1, busf.au_sel0, busf.au_cin}, busf.au_x, busf.au_y);
  assign busf.au_f    = au_rf[7:0];
  assign busf.au_cout = au_rf[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs_main();
    return {bus.a_ready, bus.b_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_f,
            bus.au_sel1, bus.au_sel0, bus.au_cin, bus.au_x, bus.au_y};
  endfunction

  task automatic set_req(input logic port, input logic v, input logic [2:0] op, input logic w,
                         input logic [15:0] x, input logic [15:0] y);
    if (!port) begin
      bus.a_valid = v; bus.a_op = op; bus.a_wide = w; bus.a_x = x; bus.a_y = y;
    end else begin
      bus.b_valid = v; bus.b_op = op; bus.b_wide = w; bus.b_x = x; bus.b_y = y;
    end
  endtask

  task automatic wait_ready(input logic port, input string name);
    int n = 0;
    #1;
    while (!(port ? bus.b_ready : bus.a_ready) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) check({name, "_ready_timeout"}, 64'(n), 64'd0);
  endtask

  task automatic issue(input logic port, input logic [2:0] op, input logic wide,
                       input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] ef, input logic ec);
    int lat;
    @(negedge clk);
    set_req(port, 1'b1, op, wide, x, y);
    sb.push_back('{port, ef, ec});
    last_id = port;
    wait_ready(port, "issue");
    @(posedge clk);
    @(negedge clk);
    set_req(port, 1'b0, 3'b000, 1'b0, 16'h0, 16'h0);
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!bus.rsp_valid && lat < 8);
    check("latency", 64'(lat), wide ? 64'd2 : 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // scoreboard: one pop per response handshake
  always begin
    exp_t e;
    @(negedge clk); #2;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(bus.rsp_f), 64'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("rsp", {bus.rsp_id, bus.rsp_f, bus.rsp_cout}, {e.id, e.f, e.cout});
      end
    end
  end

  always begin
    @(negedge clk); #2;
    if (rst_n && busf.rsp_valid && busf.rsp_ready) begin
      nf++;
      check("fixed_rsp", {busf.rsp_id, busf.rsp_f, busf.rsp_cout}, {1'b0, 16'h0008, 1'b0});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc;
    logic first, g;
    logic [16:0] r;
    logic p, w;
    logic [2:0] op;
    logic [15:0] x, y;

    tbl[0]  = '{1'b0, 3'b010, 1'b1, 16'h12FF, 16'h0001, 16'h1300, 1'b0};
    tbl[1]  = '{1'b1, 3'b100, 1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b1};
    tbl[2]  = '{1'b0, 3'b110, 1'b1, 16'h0100, 16'h0000, 16'h00FF, 1'b1};
    tbl[3]  = '{1'b1, 3'b110, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 1'b0};
    tbl[4]  = '{1'b0, 3'b001, 1'b0, 16'h00FF, 16'h0000, 16'h0000, 1'b1};
    tbl[5]  = '{1'b1, 3'b011, 1'b1, 16'h00FF, 16'h00FF, 16'h01FF, 1'b0};
    tbl[6]  = '{1'b0, 3'b101, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 1'b0};
    tbl[7]  = '{1'b1, 3'b111, 1'b1, 16'h1234, 16'hABCD, 16'hABCD, 1'b0};
    tbl[8]  = '{1'b0, 3'b111, 1'b0, 16'h1234, 16'hABCD, 16'h00CD, 1'b0};
    tbl[9]  = '{1'b1, 3'b000, 1'b1, 16'hBEEF, 16'h1111, 16'hBEEF, 1'b0};
    tbl[10] = '{1'b0, 3'b010, 1'b0, 16'h12F0, 16'h3420, 16'h0010, 1'b1};
    tbl[11] = '{1'b1, 3'b110, 1'b1, 16'h0105, 16'h0000, 16'h0104, 1'b1};
    tbl[12] = '{1'b0, 3'b100, 1'b0, 16'h0003, 16'h0005, 16'h00FE, 1'b0};
    tbl[13] = '{1'b1, 3'b001, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
    exp_a = '{1'b0, 16'h0008, 1'b0};
    exp_b = '{1'b1, 16'h0002, 1'b1};

    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 3'b000, 1'b0, 16'h0, 16'h0);
    set_req(1'b1, 1'b0, 3'b000, 1'b0, 16'h0, 16'h0);
    bus.rsp_ready = 1'b1;
    busf.a_valid = 1'b0; busf.a_op = 3'b000; busf.a_wide = 1'b0; busf.a_x = 16'h0; busf.a_y = 16'h0;
    busf.b_valid = 1'b0; busf.b_op = 3'b000; busf.b_wide = 1'b0; busf.b_x = 16'h0; busf.b_y = 16'h0;
    busf.rsp_ready = 1'b1;
    last_id = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("reset_outputs", outs_main(), 64'd0);
    rst_n = 1'b1;

    foreach (tbl[i])
      issue(tbl[i].port, tbl[i].op, tbl[i].wide, tbl[i].x, tbl[i].y, tbl[i].f, tbl[i].cout);

    for (int i = 0; i < 8; i++) begin
      p  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      x  = 16'($urandom);
      y  = 16'($urandom);
      r  = ref_op(op, w, x, y);
      issue(p, op, w, x, y, r[15:0], r[16]);
    end

    // back-pressure: response held, nobody accepted
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 3'b011, 1'b0, 16'h0010, 16'h0020);
    sb.push_back('{1'b0, 16'h0031, 1'b0});
    last_id = 1'b0;
    wait_ready(1'b0, "stall");
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'b000, 1'b0, 16'h0, 16'h0);
    n = 0;
    while (!bus.rsp_valid && n < 10) begin @(negedge clk); n++; end
    check("stall_rsp_timeout", 64'(n < 10), 64'd1);
    set_req(1'b0, 1'b1, 3'b010, 1'b0, 16'h0001, 16'h0001);
    set_req(1'b1, 1'b1, 3'b010, 1'b0, 16'h0002, 16'h0002);
    repeat (3) begin
      @(negedge clk); #1;
      check("stall_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_f, bus.rsp_cout, bus.a_ready, bus.b_ready},
            {1'b1, 1'b0, 16'h0031, 1'b0, 1'b0, 1'b0});
    end
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'b000, 1'b0, 16'h0, 16'h0);
    set_req(1'b1, 1'b0, 3'b000, 1'b0, 16'h0, 16'h0);
    bus.rsp_ready = 1'b1;
    drain();

    // round-robin with both valid continuously
    @(negedge clk);
    first = ~last_id;
    for (int i = 0; i < 4; i++) sb.push_back((first ^ i[0]) ? exp_b : exp_a);
    set_req(1'b0, 1'b1, 3'b010, 1'b0, 16'h0005, 16'h0003);
    set_req(1'b1, 1'b1, 3'b100, 1'b0, 16'h0005, 16'h0003);
    n = 0; cyc = 0;
    while (n < 4 && cyc < 200) begin
      #1;
      if (bus.a_ready || bus.b_ready) begin
        g = first ^ n[0];
        check("rr_grant", {bus.a_ready, bus.b_ready}, g ? 64'd1 : 64'd2);
        n++;
      end
      if (n < 4) begin @(negedge clk); cyc++; end
    end
    check("rr_count", 64'(n), 64'd4);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'b000, 1'b0, 16'h0, 16'h0);
    set_req(1'b1, 1'b0, 3'b000, 1'b0, 16'h0, 16'h0);
    last_id = ~first;
    drain();

    // fixed priority instance: A always wins
    @(negedge clk);
    busf.a_valid = 1'b1; busf.a_op = 3'b001; busf.a_x = 16'h0007;
    busf.b_valid = 1'b1; busf.b_op = 3'b010; busf.b_x = 16'h0001; busf.b_y = 16'h0001;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 200) begin
      #1;
      if (busf.a_ready || busf.b_ready) begin
        check("fixed_grant", {busf.a_ready, busf.b_ready}, 64'd2);
        n++;
      end
      if (n < 3) begin @(negedge clk); cyc++; end
    end
    check("fixed_count", 64'(n), 64'd3);
    @(posedge clk);
    @(negedge clk);
    busf.a_valid = 1'b0; busf.b_valid = 1'b0;
    cyc = 0;
    while (nf < 3 && cyc < 50) begin @(negedge clk); cyc++; end
    check("fixed_rsp_count", 64'(nf), 64'd3);

    // reset during the high pass
    @(negedge clk);
    set_req(1'b1, 1'b1, 3'b010, 1'b1, 16'h1234, 16'h1111);
    wait_ready(1'b1, "rst_op");
    @(posedge clk);
    @(negedge clk);
    set_req(1'b1, 1'b0, 3'b000, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    check("hi_drive", {bus.rsp_id, bus.au_sel1, bus.au_sel0, bus.au_cin, bus.au_x, bus.au_y},
          {1'b1, 3'b010, 8'h12, 8'h11});
    rst_n = 1'b0;
    #1 check("reset_mid_op", outs_main(), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_id = 1'b1;
    issue(1'b1, 3'b001, 1'b0, 16'h0041, 16'h0000, 16'h0042, 1'b0);
    @(negedge clk);
    set_req(1'b0, 1'b1, 3'b000, 1'b0, 16'h0055, 16'h0000);
    set_req(1'b1, 1'b1, 3'b111, 1'b0, 16'h0000, 16'h0066);
    sb.push_back('{1'b0, 16'h0055, 1'b0});
    n = 0;
    #1;
    while (!(bus.a_ready || bus.b_ready) && n < 50) begin @(negedge clk); #1; n++; end
    check("post_reset_grant", {bus.a_ready, bus.b_ready}, 64'd2);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'b000, 1'b0, 16'h0, 16'h0);
    set_req(1'b1, 1'b0, 3'b000, 1'b0, 16'h0, 16'h0);
    last_id = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
